// File: rtl/axi_splitter_pkg.sv
// Shared constants and types for the four-channel weight splitter.
package axi_splitter_pkg;

  localparam int DATA_WIDTH    = 128;
  localparam int SAMPLE_WIDTH  = 16;
  localparam int WEIGHT_WIDTH  = 8;
  localparam int LANES         = DATA_WIDTH / SAMPLE_WIDTH;
  localparam int NUM_CH        = 4;
  localparam int PRODUCT_WIDTH = SAMPLE_WIDTH + WEIGHT_WIDTH;

  // Q1.7 weights: round half up, then drop the seven fractional bits.
  localparam int ROUND_CONST = 64;
  localparam int FRAC_BITS   = 7;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  // One holding-register entry: weighted samples plus the frame marker.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } beat_t;

endpackage

// File: rtl/axi_weight_splitter_weight_lane.sv
// One-sample scaler: signed sample times signed Q1.7 weight, rounded half
// up and saturated back to the sample width. Purely combinational.
module weight_lane
  import axi_splitter_pkg::*;
(
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic [WEIGHT_WIDTH-1:0] weight,
  output logic [SAMPLE_WIDTH-1:0] result
);

  // One guard bit above the product so the round constant can never wrap.
  localparam int WIDE = PRODUCT_WIDTH + 1;
  localparam logic signed [WIDE-1:0] ROUND_W = WIDE'(ROUND_CONST);
  localparam logic signed [WIDE-1:0] MAX_W   = WIDE'(SAT_MAX);
  localparam logic signed [WIDE-1:0] MIN_W   = WIDE'(SAT_MIN);

  logic signed [PRODUCT_WIDTH-1:0] product;
  logic signed [WIDE-1:0]          rounded;
  logic signed [WIDE-1:0]          shifted;

  assign product = PRODUCT_WIDTH'($signed(sample)) * PRODUCT_WIDTH'($signed(weight));
  assign rounded = WIDE'(product) + ROUND_W;
  assign shifted = rounded >>> FRAC_BITS;

  // Clamp the scaled value; only -32768 * -128 can actually exceed the range.
  always_comb begin
    if (shifted > MAX_W) begin
      result = MAX_W[SAMPLE_WIDTH-1:0];
    end else if (shifted < MIN_W) begin
      result = MIN_W[SAMPLE_WIDTH-1:0];
    end else begin
      result = shifted[SAMPLE_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/axi_weight_splitter.sv
// Broadcast stage: scales each input beat by four per-channel weights and
// fans it out to four AXI4-Stream masters, each with a one-beat holding
// register. A beat is accepted only when every channel can take it.
module axi_weight_splitter
  import axi_splitter_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic [WEIGHT_WIDTH-1:0] bWeight00,
  input  logic [WEIGHT_WIDTH-1:0] bWeight01,
  input  logic [WEIGHT_WIDTH-1:0] bWeight20,
  input  logic [WEIGHT_WIDTH-1:0] bWeight21,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [DATA_WIDTH-1:0]   M00_axis_tdata,
  output logic                    M00_axis_tvalid,
  input  logic                    M00_axis_tready,
  output logic                    M00_axis_tlast,
  output logic [DATA_WIDTH-1:0]   M01_axis_tdata,
  output logic                    M01_axis_tvalid,
  input  logic                    M01_axis_tready,
  output logic                    M01_axis_tlast,
  output logic [DATA_WIDTH-1:0]   M20_axis_tdata,
  output logic                    M20_axis_tvalid,
  input  logic                    M20_axis_tready,
  output logic                    M20_axis_tlast,
  output logic [DATA_WIDTH-1:0]   M21_axis_tdata,
  output logic                    M21_axis_tvalid,
  input  logic                    M21_axis_tready,
  output logic                    M21_axis_tlast
);

  logic [NUM_CH-1:0][WEIGHT_WIDTH-1:0] weight;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]   scaled;
  logic [NUM_CH-1:0]                   ready;
  logic [NUM_CH-1:0]                   valid;
  beat_t [NUM_CH-1:0]                  hold;
  logic                                accept;

  // Channel index order is 00, 01, 20, 21 throughout.
  assign weight[0] = bWeight00;
  assign weight[1] = bWeight01;
  assign weight[2] = bWeight20;
  assign weight[3] = bWeight21;

  assign ready[0] = M00_axis_tready;
  assign ready[1] = M01_axis_tready;
  assign ready[2] = M20_axis_tready;
  assign ready[3] = M21_axis_tready;

  assign M00_axis_tdata  = hold[0].data;
  assign M00_axis_tlast  = hold[0].last;
  assign M00_axis_tvalid = valid[0];
  assign M01_axis_tdata  = hold[1].data;
  assign M01_axis_tlast  = hold[1].last;
  assign M01_axis_tvalid = valid[1];
  assign M20_axis_tdata  = hold[2].data;
  assign M20_axis_tlast  = hold[2].last;
  assign M20_axis_tvalid = valid[2];
  assign M21_axis_tdata  = hold[3].data;
  assign M21_axis_tlast  = hold[3].last;
  assign M21_axis_tvalid = valid[3];

  // A channel can take a new beat if it is empty or draining this cycle;
  // deliberately independent of s_axis_tvalid.
  assign s_axis_tready = &(~valid | ready);
  assign accept        = s_axis_tvalid & s_axis_tready;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    for (genvar ln = 0; ln < LANES; ln++) begin : g_lane
      weight_lane u_lane (
        .sample (s_axis_tdata[ln*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
        .weight (weight[ch]),
        .result (scaled[ch][ln*SAMPLE_WIDTH +: SAMPLE_WIDTH])
      );
    end
  end

  // Load all channels together on accept; otherwise each drains on its own ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
      hold  <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (accept) begin
          hold[ch].data <= scaled[ch];
          hold[ch].last <= s_axis_tlast;
          valid[ch]     <= 1'b1;
        end else if (ready[ch]) begin
          valid[ch] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_weight_splitter.sv
// Testbench for axi_weight_splitter: directed steps plus randomized traffic
// checked against a per-channel queue scoreboard.
module tb_axi_weight_splitter;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } exp_beat_t;

  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   w [4];
  logic [127:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [3:0]   rdy;

  logic [127:0] M00_axis_tdata, M01_axis_tdata, M20_axis_tdata, M21_axis_tdata;
  logic         M00_axis_tvalid, M01_axis_tvalid, M20_axis_tvalid, M21_axis_tvalid;
  logic         M00_axis_tlast, M01_axis_tlast, M20_axis_tlast, M21_axis_tlast;

  logic [127:0] m_data  [4];
  logic         m_valid [4];
  logic         m_last  [4];

  exp_beat_t q [4][$];
  int delivered [4];
  int last_seen [4];
  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  axi_weight_splitter dut (
    .clock           (clock),
    .reset           (reset),
    .bWeight00       (w[0]),
    .bWeight01       (w[1]),
    .bWeight20       (w[2]),
    .bWeight21       (w[3]),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .M00_axis_tdata  (M00_axis_tdata),
    .M00_axis_tvalid (M00_axis_tvalid),
    .M00_axis_tready (rdy[0]),
    .M00_axis_tlast  (M00_axis_tlast),
    .M01_axis_tdata  (M01_axis_tdata),
    .M01_axis_tvalid (M01_axis_tvalid),
    .M01_axis_tready (rdy[1]),
    .M01_axis_tlast  (M01_axis_tlast),
    .M20_axis_tdata  (M20_axis_tdata),
    .M20_axis_tvalid (M20_axis_tvalid),
    .M20_axis_tready (rdy[2]),
    .M20_axis_tlast  (M20_axis_tlast),
    .M21_axis_tdata  (M21_axis_tdata),
    .M21_axis_tvalid (M21_axis_tvalid),
    .M21_axis_tready (rdy[3]),
    .M21_axis_tlast  (M21_axis_tlast)
  );

  assign m_data[0]  = M00_axis_tdata;
  assign m_data[1]  = M01_axis_tdata;
  assign m_data[2]  = M20_axis_tdata;
  assign m_data[3]  = M21_axis_tdata;
  assign m_valid[0] = M00_axis_tvalid;
  assign m_valid[1] = M01_axis_tvalid;
  assign m_valid[2] = M20_axis_tvalid;
  assign m_valid[3] = M21_axis_tvalid;
  assign m_last[0]  = M00_axis_tlast;
  assign m_last[1]  = M01_axis_tlast;
  assign m_last[2]  = M20_axis_tlast;
  assign m_last[3]  = M21_axis_tlast;

  // Reference scaling: real-valued w/128 times sample, rounded half up, clamped.
  function automatic logic [15:0] ref_lane(input logic [15:0] s, input logic [7:0] wt);
    longint p;
    longint r;
    p = longint'($signed(s)) * longint'($signed(wt)) + 64;
    if (p >= 0) r = p / 128;
    else        r = -((-p + 127) / 128);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  function automatic logic [127:0] ref_beat(input logic [127:0] d, input logic [7:0] wt);
    logic [127:0] o;
    o = '0;
    for (int ln = 0; ln < 8; ln++) o[ln*16 +: 16] = ref_lane(d[ln*16 +: 16], wt);
    return o;
  endfunction

  task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Compare DUT against the scoreboard at the negedge, then update the model
  // for whatever handshakes the coming posedge will perform.
  task automatic model_step();
    logic exp_ready;
    bit   pop [4];
    exp_beat_t b;
    exp_ready = 1'b1;
    for (int k = 0; k < 4; k++)
      if (q[k].size() != 0 && !rdy[k]) exp_ready = 1'b0;
    check_output("s_tready", 128'(s_axis_tready), 128'(exp_ready));
    for (int k = 0; k < 4; k++) begin
      pop[k] = 1'b0;
      check_output($sformatf("tvalid_ch%0d", k), 128'(m_valid[k]), 128'(q[k].size() != 0));
      if (q[k].size() != 0 && rdy[k]) begin
        check_output($sformatf("tdata_ch%0d", k), m_data[k], q[k][0].data);
        check_output($sformatf("tlast_ch%0d", k), 128'(m_last[k]), 128'(q[k][0].last));
        pop[k] = 1'b1;
        delivered[k]++;
        if (q[k][0].last) last_seen[k]++;
      end
    end
    for (int k = 0; k < 4; k++)
      if (pop[k]) void'(q[k].pop_front());
    if (s_axis_tvalid && exp_ready) begin
      for (int k = 0; k < 4; k++) begin
        b.data = ref_beat(s_axis_tdata, w[k]);
        b.last = s_axis_tlast;
        q[k].push_back(b);
      end
    end
  endtask

  // Drive one cycle of inputs, check at the negedge, end just after the posedge.
  task automatic apply_stimulus(input logic valid, input logic [127:0] data,
                                input logic last, input logic [3:0] ready);
    s_axis_tvalid = valid;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    rdy           = ready;
    @(negedge clock);
    model_step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [127:0] rand_data();
    logic [127:0] d;
    for (int i = 0; i < 4; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic clear_counts();
    for (int k = 0; k < 4; k++) begin
      delivered[k] = 0;
      last_seen[k] = 0;
    end
  endtask

  initial begin
    logic [127:0] d;
    reset         = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    rdy           = 4'b1111;
    for (int k = 0; k < 4; k++) w[k] = 8'd64;
    clear_counts();

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("rst_tvalid_ch%0d", k), 128'(m_valid[k]), 128'(0));
      check_output($sformatf("rst_tdata_ch%0d", k), m_data[k], 128'(0));
      check_output($sformatf("rst_tlast_ch%0d", k), 128'(m_last[k]), 128'(0));
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_output("tready_after_reset", 128'(s_axis_tready), 128'(1));

    // Basic beat: lane0 = 1000 at weight 0.5
    d = '0;
    d[15:0] = 16'd1000;
    apply_stimulus(1'b1, d, 1'b0, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("basic_valid_ch%0d", k), 128'(m_valid[k]), 128'(1));
      check_output($sformatf("basic_lane0_ch%0d", k), 128'(m_data[k][15:0]), 128'(16'd500));
    end
    check_output("basic_tready", 128'(s_axis_tready), 128'(1));
    apply_stimulus(1'b0, '0, 1'b0, 4'b1111);

    // Rounding: 3 -> 2, -3 -> -1 at weight 64
    d = '0;
    d[15:0]  = 16'd3;
    d[31:16] = 16'hFFFD;
    apply_stimulus(1'b1, d, 1'b0, 4'b1111);
    check_output("round_pos", 128'(M00_axis_tdata[15:0]), 128'(16'd2));
    check_output("round_neg", 128'(M00_axis_tdata[31:16]), 128'(16'hFFFF));

    // Saturation at weight -1.0
    for (int k = 0; k < 4; k++) w[k] = 8'h80;
    d = '0;
    d[15:0]  = 16'h8000;
    d[31:16] = 16'h7FFF;
    apply_stimulus(1'b1, d, 1'b0, 4'b1111);
    check_output("sat_min_neg", 128'(M21_axis_tdata[15:0]), 128'(16'h7FFF));
    check_output("sat_max_neg", 128'(M21_axis_tdata[31:16]), 128'(16'h8001));

    // Weight 0 still produces a valid beat
    for (int k = 0; k < 4; k++) w[k] = 8'd0;
    apply_stimulus(1'b1, rand_data(), 1'b0, 4'b1111);
    check_output("zero_weight_valid", 128'(M01_axis_tvalid), 128'(1));
    check_output("zero_weight_data", M01_axis_tdata, 128'(0));
    apply_stimulus(1'b0, '0, 1'b0, 4'b1111);

    // Stall channel 20 for 5 cycles while streaming
    for (int k = 0; k < 4; k++) w[k] = 8'($urandom);
    clear_counts();
    repeat (5) apply_stimulus(1'b1, rand_data(), 1'b0, 4'b1011);
    check_output("stall_ch00_one_beat", 128'(delivered[0]), 128'(1));
    check_output("stall_ch20_none", 128'(delivered[2]), 128'(0));
    repeat (6) apply_stimulus(1'b1, rand_data(), 1'b0, 4'b1111);
    repeat (2) apply_stimulus(1'b0, '0, 1'b0, 4'b1111);
    for (int k = 1; k < 4; k++)
      check_output($sformatf("stall_equal_ch%0d", k), 128'(delivered[k]), 128'(delivered[0]));

    // 16-beat frame, weight of channel 01 changes mid-frame
    for (int k = 0; k < 4; k++) w[k] = 8'($urandom);
    clear_counts();
    for (int i = 1; i <= 16; i++) begin
      if (i == 9) w[1] = w[1] ^ 8'h5A;
      apply_stimulus(1'b1, rand_data(), (i == 16), 4'b1111);
    end
    apply_stimulus(1'b0, '0, 1'b0, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("frame_beats_ch%0d", k), 128'(delivered[k]), 128'(16));
      check_output($sformatf("frame_last_ch%0d", k), 128'(last_seen[k]), 128'(1));
    end

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 7) == 0) w[k] = 8'($urandom);
      apply_stimulus(1'($urandom_range(0, 3) != 0), rand_data(), 1'($urandom_range(0, 7) == 0),
                     4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15)));
    end
    repeat (3) apply_stimulus(1'b0, '0, 1'b0, 4'b1111);

    // Reset while every channel holds an unconsumed beat
    apply_stimulus(1'b1, rand_data(), 1'b1, 4'b0000);
    apply_stimulus(1'b0, '0, 1'b0, 4'b0000);
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("midrst_tvalid_ch%0d", k), 128'(m_valid[k]), 128'(0));
      check_output($sformatf("midrst_tdata_ch%0d", k), m_data[k], 128'(0));
      check_output($sformatf("midrst_tlast_ch%0d", k), 128'(m_last[k]), 128'(0));
      q[k].delete();
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    for (int k = 0; k < 4; k++) w[k] = 8'($urandom);
    apply_stimulus(1'b1, rand_data(), 1'b0, 4'b1111);
    repeat (3) apply_stimulus(1'b0, '0, 1'b0, 4'b1111);
    for (int k = 0; k < 4; k++)
      check_output($sformatf("drained_ch%0d", k), 128'(q[k].size()), 128'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
